// File: rtl/regf_wb_arbiter.sv
// Arbitrates the register file write port between pipeline writeback (A) and mul/div (B),
// with a starvation bound for B and a busy scoreboard for outstanding B destinations.
module regf_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd_s,
  input  logic [31:0] a_rd_v,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd_s,
  input  logic [31:0] b_rd_v,
  output logic        b_ready,
  input  logic        busy_set,
  input  logic [4:0]  busy_set_s,
  input  logic [4:0]  rs1_s,
  input  logic [4:0]  rs2_s,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        regf_we,
  output logic [4:0]  rd_s,
  output logic [31:0] rd_v
);

  localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

  logic [3:0]  starve_q, starve_d;
  logic [31:0] busy_q, busy_d;
  logic        a_real, b_real, grant_a, grant_b;

  always_comb begin
    a_real  = a_valid && (a_rd_s != 5'd0);
    b_real  = b_valid && (b_rd_s != 5'd0);
    grant_b = !rst && b_real && (!a_real || (starve_q == StarveLim));
    grant_a = !rst && a_real && !grant_b;

    // x0 requests complete without occupying the port
    a_ready = !rst && a_valid && ((a_rd_s == 5'd0) || grant_a);
    b_ready = !rst && b_valid && ((b_rd_s == 5'd0) || grant_b);

    regf_we = 1'b0;
    rd_s    = 5'd0;
    rd_v    = 32'd0;
    if (grant_a) begin
      regf_we = 1'b1;
      rd_s    = a_rd_s;
      rd_v    = a_rd_v;
    end else if (grant_b) begin
      regf_we = 1'b1;
      rd_s    = b_rd_s;
      rd_v    = b_rd_v;
    end

    starve_d = starve_q;
    if (!b_valid || grant_b) begin
      starve_d = 4'd0;
    end else if (b_real && grant_a && (starve_q < StarveLim)) begin
      starve_d = starve_q + 4'd1;
    end

    // Set after clear so a fresh issue to the same index wins
    busy_d = busy_q;
    if (grant_b) begin
      busy_d[b_rd_s] = 1'b0;
    end
    if (busy_set && (busy_set_s != 5'd0)) begin
      busy_d[busy_set_s] = 1'b1;
    end

    rs1_busy = !rst && (rs1_s != 5'd0) && busy_q[rs1_s];
    rs2_busy = !rst && (rs2_s != 5'd0) && busy_q[rs2_s];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
      busy_q   <= 32'd0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_regf_wb_arbiter.sv
// Directed-vector bench: driver queues expected outputs per cycle, monitor pops and checks.
module tb_regf_wb_arbiter;

  typedef struct packed {
    logic        ar;
    logic        br;
    logic        we;
    logic [4:0]  rds;
    logic [31:0] rdv;
    logic        r1b;
    logic        r2b;
  } exp_t;

  typedef struct packed {
    int   id;
    exp_t e;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, busy_set = 1'b0;
  logic [4:0]  a_rd_s = '0, b_rd_s = '0, busy_set_s = '0, rs1_s = '0, rs2_s = '0;
  logic [31:0] a_rd_v = '0, b_rd_v = '0;
  logic        a_ready, b_ready, rs1_busy, rs2_busy, regf_we;
  logic [4:0]  rd_s;
  logic [31:0] rd_v;

  item_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    vid = 0;

  regf_wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd_s(a_rd_s), .a_rd_v(a_rd_v), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd_s(b_rd_s), .b_rd_v(b_rd_v), .b_ready(b_ready),
    .busy_set(busy_set), .busy_set_s(busy_set_s),
    .rs1_s(rs1_s), .rs2_s(rs2_s), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .regf_we(regf_we), .rd_s(rd_s), .rd_v(rd_v)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic ar, br, we, input logic [4:0] rds,
                              input logic [31:0] rdv, input logic r1b, r2b);
    exp_t e;
    e.ar = ar; e.br = br; e.we = we; e.rds = rds; e.rdv = rdv; e.r1b = r1b; e.r2b = r2b;
    return e;
  endfunction

  task automatic vec(input logic r, input logic av, input logic [4:0] as, input logic [31:0] ad,
                     input logic bv, input logic [4:0] bs, input logic [31:0] bd,
                     input logic st, input logic [4:0] ss,
                     input logic [4:0] r1, input logic [4:0] r2, input exp_t e);
    item_t it;
    @(posedge clk);
    #1;
    rst = r; a_valid = av; a_rd_s = as; a_rd_v = ad;
    b_valid = bv; b_rd_s = bs; b_rd_v = bd;
    busy_set = st; busy_set_s = ss; rs1_s = r1; rs2_s = r2;
    it.id = vid; it.e = e;
    exp_q.push_back(it);
    vid++;
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      item_t it;
      exp_t  got;
      it  = exp_q.pop_front();
      got = mk(a_ready, b_ready, regf_we, rd_s, rd_v, rs1_busy, rs2_busy);
      total++;
      if (got !== it.e) begin
        bad++;
        $display("FAIL vec%0d: got ar=%b br=%b we=%b rd=%0d v=%h b1=%b b2=%b, want ar=%b br=%b we=%b rd=%0d v=%h b1=%b b2=%b",
                 it.id, got.ar, got.br, got.we, got.rds, got.rdv, got.r1b, got.r2b,
                 it.e.ar, it.e.br, it.e.we, it.e.rds, it.e.rdv, it.e.r1b, it.e.r2b);
      end
    end
  end

  exp_t z;

  initial begin
    z = mk(0, 0, 0, 0, 0, 0, 0);
    // Reset with requests and busy_set active
    vec(1, 1, 3, 32'h33, 1, 7, 32'h77, 1, 4, 4, 7, z);
    vec(1, 1, 3, 32'h33, 1, 7, 32'h77, 1, 4, 4, 7, z);
    // Scoreboard empty after reset
    for (int i = 0; i < 32; i++) vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i), z);
    // A alone
    vec(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 5, 32'hDEADBEEF, 0, 0));
    // Starvation: A wins 4 times, B forced on the 5th, then A again
    for (int i = 0; i < 4; i++)
      vec(0, 1, 3, 32'h33, 1, 7, 32'h77, 0, 0, 0, 0, mk(1, 0, 1, 3, 32'h33, 0, 0));
    vec(0, 1, 3, 32'h33, 1, 7, 32'h77, 0, 0, 0, 0, mk(0, 1, 1, 7, 32'h77, 0, 0));
    vec(0, 1, 3, 32'h34, 1, 7, 32'h78, 0, 0, 0, 0, mk(1, 0, 1, 3, 32'h34, 0, 0));
    // x0 bypass
    vec(0, 1, 0, 32'h11, 1, 9, 32'h99, 0, 0, 0, 0, mk(1, 1, 1, 9, 32'h99, 0, 0));
    vec(0, 1, 6, 32'h66, 1, 0, 32'h22, 0, 0, 0, 0, mk(1, 1, 1, 6, 32'h66, 0, 0));
    // Scoreboard set / clear / set-wins
    vec(0, 0, 0, 0, 0, 0, 0, 1, 12, 12, 12, z);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 12, mk(0, 0, 0, 0, 0, 1, 1));
    vec(0, 0, 0, 0, 1, 12, 32'hC0, 0, 0, 12, 11, mk(0, 1, 1, 12, 32'hC0, 1, 0));
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 12, z);
    vec(0, 0, 0, 0, 0, 0, 0, 1, 12, 12, 0, z);
    vec(0, 0, 0, 0, 1, 12, 32'hC1, 1, 12, 12, 0, mk(0, 1, 1, 12, 32'hC1, 1, 0));
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0, mk(0, 0, 0, 0, 0, 1, 0));
    // A write to a busy index leaves it busy
    vec(0, 1, 12, 32'hA0, 0, 0, 0, 0, 0, 12, 0, mk(1, 0, 1, 12, 32'hA0, 1, 0));
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, mk(0, 0, 0, 0, 0, 0, 1));
    // Reset mid-operation: busy[4] set, starve count at 3
    vec(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, z);
    for (int i = 0; i < 3; i++)
      vec(0, 1, 3, 32'h33, 1, 7, 32'h77, 0, 0, 4, 0, mk(1, 0, 1, 3, 32'h33, 1, 0));
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 12, z);
    for (int i = 0; i < 4; i++)
      vec(0, 1, 3, 32'h33, 1, 7, 32'h77, 0, 0, 4, 12, mk(1, 0, 1, 3, 32'h33, 0, 0));
    vec(0, 1, 3, 32'h33, 1, 7, 32'h77, 0, 0, 4, 12, mk(0, 1, 1, 7, 32'h77, 0, 0));
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, z);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
